// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the width helper for the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bus between a controller (master) and the serial subtractor (slave).
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         borrow;
  logic         overflow;

  modport master (
    output start, A, B, bin,
    input  busy, done, D, borrow, overflow
  );

  modport slave (
    input  start, A, B, bin,
    output busy, done, D, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtract cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, D = A - B - bin, with a
// start/busy/done handshake. One full_subtractor cell is reused every cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state_reg, state_next;
  logic [N-1:0]       a_reg, b_reg, res_reg, d_reg;
  logic               br_reg, borrow_reg, ovf_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               diff_bit, bout;
  logic               last_bit;
  logic [N-1:0]       res_next;

  full_subtractor u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (br_reg),
    .d    (diff_bit),
    .bout (bout)
  );

  assign last_bit = (cnt_reg == CNT_LAST);
  // Result fills from the MSB side so the first (LSB) bit lands at bit 0 after N shifts.
  assign res_next = {diff_bit, res_reg[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B;
            br_reg  <= bus.bin;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= bout;
          res_reg <= res_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            d_reg      <= res_next;
            borrow_reg <= bout;
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            ovf_reg    <= br_reg ^ bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg == SHIFT);
  assign bus.done     = (state_reg == DONE);
  assign bus.D        = d_reg;
  assign bus.borrow   = borrow_reg;
  assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake
// corner cases, and random operands checked against an arithmetic model.
module tb_serial_subtractor;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference from plain integer arithmetic on the operand values.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic borrow, output logic ovf);
    int ua, ub, sa, sb, udiff, sdiff;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    udiff  = ua - ub - int'(bin);
    sdiff  = sa - sb - int'(bin);
    d      = 8'((udiff + 512) % 256);
    borrow = (udiff < 0);
    ovf    = (sdiff < -128) || (sdiff > 127);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  // inject >= 0 pulses a conflicting start during that SHIFT cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int inject);
    bus.A = a; bus.B = b; bus.bin = bin; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.bin = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      check("busy_shift", 32'(bus.busy), 32'd1);
      check("done_shift", 32'(bus.done), 32'd0);
      if (i == inject) begin
        bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd0);
    $display("op A=%02h B=%02h bin=%0d -> D=%02h borrow=%0d ovf=%0d (exp %02h %0d %0d)",
             a, b, bin, bus.D, bus.borrow, bus.overflow, ed, eb, eo);
    check("D", 32'(bus.D), 32'(ed));
    check("borrow", 32'(bus.borrow), 32'(eb));
    check("overflow", 32'(bus.overflow), 32'(eo));
    @(posedge clk); @(negedge clk);
    check("done_clear", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb, md;
    logic       rbin, mb, mo;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bin = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_D", 32'(bus.D), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++)
      run_op(vecs[k].a, vecs[k].b, vecs[k].bin, vecs[k].d, vecs[k].borrow, vecs[k].ovf, -1);

    // Conflicting start during SHIFT cycle 3 must be ignored.
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 3);
    bus.A = 8'h33; bus.B = 8'h11;
    for (int i = 0; i < 4; i++) begin
      check("idle_no_done", 32'(bus.done), 32'd0);
      check("idle_hold_D", 32'(bus.D), 32'h0F);
      @(posedge clk); @(negedge clk);
    end

    // Asynchronous reset mid-SHIFT after a result with both flags set.
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, -1);
    bus.A = 8'h55; bus.B = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_D", 32'(bus.D), 32'd0);
    check("arst_borrow", 32'(bus.borrow), 32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      check("arst_no_done", 32'(bus.done), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, -1);

    // Random operands, back-to-back from the cycle after done.
    for (int k = 0; k < 30; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      model(ra, rb, rbin, md, mb, mo);
      run_op(ra, rb, rbin, md, mb, mo, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
